// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch/decode slice.
// Holds the opcode constants, the fetch FSM states and the default reset PC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/mips_next_pc.sv
// Redirect resolver: decides whether a jump/branch is taken and computes the target.
// A jump takes priority over a branch; the low two bits of the target are always cleared.
module mips_next_pc #(
    parameter int ADDR_W = 32
) (
    input  logic              redir_valid,
    input  logic              redir_jump,
    input  logic              redir_branch,
    input  logic              redir_zero,
    input  logic [ADDR_W-1:0] redir_pc_plus4,
    input  logic [15:0]       redir_imm,
    input  logic [25:0]       redir_jidx,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    localparam logic [ADDR_W-1:0] SEG_MASK = ADDR_W'(32'h0FFF_FFFF);

    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] raw_tgt;

    // Jumps keep the upper segment bits of pc+4; branches add the scaled signed offset.
    always_comb begin
        jump_tgt   = (redir_pc_plus4 & ~SEG_MASK) | ADDR_W'({redir_jidx, 2'b00});
        branch_tgt = redir_pc_plus4 + {{(ADDR_W-18){redir_imm[15]}}, redir_imm, 2'b00};
        raw_tgt    = redir_jump ? jump_tgt : branch_tgt;
        target     = {raw_tgt[ADDR_W-1:2], 2'b00};
        taken      = redir_valid && (redir_jump || (redir_branch && redir_zero));
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, one-entry instruction buffer,
// jump/branch redirect with stale-response kill. FETCH_STATS_EN adds fetch/kill counters.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [5:0]        opcode_out,
    output logic [ADDR_W-1:0] pc_plus4_out,
    input  logic              redir_valid,
    input  logic              redir_jump,
    input  logic              redir_branch,
    input  logic              redir_zero,
    input  logic [ADDR_W-1:0] redir_pc_plus4,
    input  logic [15:0]       redir_imm,
    input  logic [25:0]       redir_jidx
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_killed
`endif
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              kill;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_seq;

    mips_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .redir_valid    (redir_valid),
        .redir_jump     (redir_jump),
        .redir_branch   (redir_branch),
        .redir_zero     (redir_zero),
        .redir_pc_plus4 (redir_pc_plus4),
        .redir_imm      (redir_imm),
        .redir_jidx     (redir_jidx),
        .taken          (taken),
        .target         (target)
    );

    assign pc_seq     = pc + ADDR_W'(4);
    assign opcode_out = instr_out[31:26];

    // A taken redirect retargets the PC in every state; the case below only decides
    // whether the in-flight or buffered fetch has to be thrown away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr_valid  <= 1'b0;
            instr_out    <= '0;
            pc_plus4_out <= '0;
        end else begin
            if (taken) begin
                pc          <= target;
                imem_addr   <= target;
                instr_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        kill     <= taken;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || taken) begin
                            kill     <= 1'b0;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            instr_out    <= imem_rdata;
                            pc_plus4_out <= pc_seq;
                            pc           <= pc_seq;
                            imem_addr    <= pc_seq;
                            instr_valid  <= 1'b1;
                            state        <= HOLD;
                        end
                    end else if (taken) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (taken || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic fetch_evt;
    logic kill_evt;

    assign fetch_evt = (state == HOLD) && instr_ready && !taken;
    assign kill_evt  = ((state == WAIT) && imem_rvalid && (kill || taken)) ||
                       ((state == HOLD) && taken);

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_killed  <= '0;
        end else begin
            if (fetch_evt && (stat_fetched != '1)) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (kill_evt && (stat_killed != '1)) begin
                stat_killed <= stat_killed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus a randomized run
// checked against an address-level model of the delivered instruction stream.
module tb_mips_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [5:0]  opcode_out;
    logic [31:0] pc_plus4_out;
    logic        redir_valid = 1'b0;
    logic        redir_jump = 1'b0;
    logic        redir_branch = 1'b0;
    logic        redir_zero = 1'b0;
    logic [31:0] redir_pc_plus4 = 32'h0;
    logic [15:0] redir_imm = 16'h0;
    logic [25:0] redir_jidx = 26'h0;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_killed;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    bit gnt_rand = 1'b0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] grant_log[$];
    int          grant_cyc[$];

    mips_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .opcode_out     (opcode_out),
        .pc_plus4_out   (pc_plus4_out),
        .redir_valid    (redir_valid),
        .redir_jump     (redir_jump),
        .redir_branch   (redir_branch),
        .redir_zero     (redir_zero),
        .redir_pc_plus4 (redir_pc_plus4),
        .redir_imm      (redir_imm),
        .redir_jidx     (redir_jidx)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_killed    (stat_killed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h8C22_0004;
    endfunction

    // One clock: log grants seen at the edge, then drive the memory's gnt/rvalid for the next edge.
    task automatic step();
        logic        granted;
        logic [31:0] gaddr;
        granted = imem_req && imem_gnt && rst_n;
        gaddr   = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (granted) begin
            pend_addr.push_back(gaddr);
            pend_due.push_back(cyc + lat);
            grant_log.push_back(gaddr);
            grant_cyc.push_back(cyc);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic clear_redir();
        redir_valid = 1'b0; redir_jump = 1'b0; redir_branch = 1'b0; redir_zero = 1'b0;
        redir_pc_plus4 = 32'h0; redir_imm = 16'h0; redir_jidx = 26'h0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_redir();
        lat = 1;
        gnt_rand = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        imem_rvalid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        ok = (instr_valid === 1'b1);
    endtask

    task automatic wait_grant(input int max, output bit ok);
        int n0 = grant_log.size();
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (grant_log.size() > n0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("[TB] FAIL rst_addr: got %h expected %h", imem_addr, RST_PC); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", instr_valid); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr: got %h expected 0", instr_out); end
        checks++; if (pc_plus4_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc4: got %h expected 0", pc_plus4_out); end
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b expected 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("[TB] FAIL first_addr: got %h expected %h", imem_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] hs_pc4[$];
        logic [31:0] hs_word[$];
        reset_dut();
        instr_ready = 1'b1;
        grant_log.delete();
        grant_cyc.delete();
        for (int i = 0; i < 30 && hs_pc4.size() < 3; i++) begin
            if (instr_valid && instr_ready) begin
                hs_pc4.push_back(pc_plus4_out);
                hs_word.push_back(instr_out);
            end
            if (hs_pc4.size() < 3) step();
        end
        checks++;
        if (hs_pc4.size() < 3 || grant_log.size() < 3) begin
            errors++; $display("[TB] FAIL seq_progress: got %0d handshakes expected 3", hs_pc4.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (grant_log[i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_addr%0d: got %h expected %h", i, grant_log[i], 32'(4 * i)); end
                checks++; if (hs_pc4[i] !== 32'(4 * i + 4)) begin errors++; $display("[TB] FAIL seq_pc4_%0d: got %h expected %h", i, hs_pc4[i], 32'(4 * i + 4)); end
                checks++; if (hs_word[i] !== word_at(32'(4 * i))) begin errors++; $display("[TB] FAIL seq_word%0d: got %h expected %h", i, hs_word[i], word_at(32'(4 * i))); end
            end
            checks++; if (grant_cyc[1] - grant_cyc[0] != 3) begin errors++; $display("[TB] FAIL seq_rate: got %0d expected 3", grant_cyc[1] - grant_cyc[0]); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        reset_dut();
        instr_ready = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_timeout: got no valid expected valid"); end
        checks++; if (pc_plus4_out !== 32'h4) begin errors++; $display("[TB] FAIL stall_pc4: got %h expected 4", pc_plus4_out); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid%0d: got %b expected 1", i, instr_valid); end
            checks++; if (instr_out !== 32'h8C22_0004) begin errors++; $display("[TB] FAIL stall_instr%0d: got %h expected 8c220004", i, instr_out); end
            checks++; if (opcode_out !== OP_LW) begin errors++; $display("[TB] FAIL stall_op%0d: got %h expected %h", i, opcode_out, OP_LW); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req%0d: got %b expected 0", i, imem_req); end
            step();
        end
        instr_ready = 1'b1;
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got %b expected 0", instr_valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL stall_next: got %h expected 4", imem_addr); end
    endtask

    task automatic test_jump();
        bit ok;
        reset_dut();
        instr_ready = 1'b0;
        wait_valid(10, ok);
        instr_ready = 1'b1;
        redir_valid = 1'b1; redir_jump = 1'b1; redir_pc_plus4 = 32'h0000_000C; redir_jidx = 26'h40;
        step();
        clear_redir();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jump_flush: got %b expected 0", instr_valid); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL jump_addr: got %h expected 100", imem_addr); end
        wait_grant(10, ok);
        checks++; if (!ok || grant_log[$] !== 32'h100) begin errors++; $display("[TB] FAIL jump_grant: got %h expected 100", grant_log[$]); end
        wait_valid(10, ok);
        checks++; if (pc_plus4_out !== 32'h104) begin errors++; $display("[TB] FAIL jump_pc4: got %h expected 104", pc_plus4_out); end
        checks++; if (instr_out !== word_at(32'h100)) begin errors++; $display("[TB] FAIL jump_word: got %h expected %h", instr_out, word_at(32'h100)); end
    endtask

    task automatic test_branch();
        bit ok;
        reset_dut();
        instr_ready = 1'b0;
        wait_valid(10, ok);
        redir_valid = 1'b1; redir_branch = 1'b1; redir_zero = 1'b1; redir_pc_plus4 = 32'h10; redir_imm = 16'hFFFE;
        step();
        clear_redir();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_flush: got %b expected 0", instr_valid); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL br_addr: got %h expected 8", imem_addr); end
        wait_valid(10, ok);
        checks++; if (pc_plus4_out !== 32'hC) begin errors++; $display("[TB] FAIL br_pc4: got %h expected c", pc_plus4_out); end
        checks++; if (instr_out !== word_at(32'h8)) begin errors++; $display("[TB] FAIL br_word: got %h expected %h", instr_out, word_at(32'h8)); end
        redir_valid = 1'b1; redir_branch = 1'b1; redir_zero = 1'b0; redir_pc_plus4 = 32'h10; redir_imm = 16'hFFFE;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        redir_valid = 1'b1; redir_branch = 1'b0; redir_jump = 1'b0; redir_zero = 1'b1;
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("[TB] FAIL br_nt_addr: got %h expected c", imem_addr); end
        step();
        clear_redir();
        wait_valid(10, ok);
        checks++; if (pc_plus4_out !== 32'h10) begin errors++; $display("[TB] FAIL br_nt_pc4: got %h expected 10", pc_plus4_out); end
    endtask

    task automatic test_wait_redirect();
        bit ok;
        reset_dut();
        lat = 3;
        instr_ready = 1'b1;
        wait_grant(10, ok);
        redir_valid = 1'b1; redir_jump = 1'b1; redir_pc_plus4 = 32'h0; redir_jidx = 26'h80;
        step();
        clear_redir();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL wr_req: got %b expected 0", imem_req); end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            int n0 = grant_log.size();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_valid%0d: got %b expected 0", i, instr_valid); end
            step();
            ok = (grant_log.size() > n0);
        end
        checks++; if (!ok || grant_log[$] !== 32'h200) begin errors++; $display("[TB] FAIL wr_grant: got %h expected 200", grant_log[$]); end
        wait_valid(10, ok);
        checks++; if (pc_plus4_out !== 32'h204) begin errors++; $display("[TB] FAIL wr_pc4: got %h expected 204", pc_plus4_out); end
        lat = 1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        reset_dut();
        instr_ready = 1'b1;
        wait_valid(10, ok);
        lat = 3;
        wait_grant(10, ok);
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("[TB] FAIL rm_addr: got %h expected %h", imem_addr, RST_PC); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL rm_instr: got %h expected 0", instr_out); end
        checks++; if (pc_plus4_out !== 32'h0) begin errors++; $display("[TB] FAIL rm_pc4: got %h expected 0", pc_plus4_out); end
        step();
        rst_n = 1'b1;
        step();
        wait_grant(10, ok);
        checks++; if (!ok || grant_log[$] !== RST_PC) begin errors++; $display("[TB] FAIL rm_grant: got %h expected %h", grant_log[$], RST_PC); end
        wait_valid(10, ok);
        checks++; if (pc_plus4_out !== 32'h4) begin errors++; $display("[TB] FAIL rm_pc4_after: got %h expected 4", pc_plus4_out); end
        checks++; if (instr_out !== word_at(RST_PC)) begin errors++; $display("[TB] FAIL rm_word: got %h expected %h", instr_out, word_at(RST_PC)); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int delivered = 0;
        reset_dut();
        gnt_rand = 1'b1;
        exp_pc = RST_PC;
        for (int i = 0; i < 3000; i++) begin
            bit          tk;
            logic [31:0] tgt;
            lat            = $urandom_range(1, 3);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redir_valid    = ($urandom_range(0, 7) == 0);
            redir_jump     = ($urandom_range(0, 2) == 0);
            redir_branch   = 1'($urandom_range(0, 1));
            redir_zero     = 1'($urandom_range(0, 1));
            redir_pc_plus4 = $urandom() & 32'hFFFF_FFFC;
            redir_imm      = 16'($urandom());
            redir_jidx     = 26'($urandom());
            tk  = 1'b0;
            tgt = 32'h0;
            if (redir_valid && redir_jump) begin
                tk  = 1'b1;
                tgt = {redir_pc_plus4[31:28], redir_jidx, 2'b00};
            end else if (redir_valid && redir_branch && redir_zero) begin
                tk  = 1'b1;
                tgt = (redir_pc_plus4 + 32'($signed(redir_imm)) * 32'd4) & 32'hFFFF_FFFC;
            end
            if (instr_valid && instr_ready && !tk) begin
                checks++; if (instr_out !== word_at(exp_pc)) begin errors++; $display("[TB] FAIL rnd_word: got %h expected %h", instr_out, word_at(exp_pc)); end
                checks++; if (pc_plus4_out !== exp_pc + 32'd4) begin errors++; $display("[TB] FAIL rnd_pc4: got %h expected %h", pc_plus4_out, exp_pc + 32'd4); end
                checks++; if (opcode_out !== word_at(exp_pc) >> 26) begin errors++; $display("[TB] FAIL rnd_op: got %h expected %h", opcode_out, word_at(exp_pc) >> 26); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (tk) exp_pc = tgt;
            step();
            if (tk) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_flush: got %b expected 0", instr_valid); end
            end
        end
        clear_redir();
        gnt_rand = 1'b0;
        checks++; if (delivered < 50) begin errors++; $display("[TB] FAIL rnd_progress: got %0d expected >=50", delivered); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch();
        test_wait_redirect();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction fetch stage that feeds the main control decoder.
- Drives the PC, issues single-outstanding requests to instruction memory, and buffers one fetched word.
- Presents the word's opcode field (instr[31:26]) to the decoder.
- Takes back the decoder's Jump/Branch decisions, plus ALU zero, to redirect the PC and discard stale fetches.

Parameters:
ADDR_W, 32, PC/address width (>=28, multiple of 4-byte words)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  word-aligned fetch address
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid (exactly one per granted request, >=1 cycle after gnt)
imem_rdata  in  32  instruction word
instr_valid  out  1  buffered instruction available
instr_ready  in  1  downstream accepts instruction
instr_out  out  32  buffered instruction
opcode_out  out  6  instr_out[31:26], to decoder control_sig
pc_plus4_out  out  ADDR_W  fetch PC + 4 of buffered instruction
redir_valid  in  1  resolution of a jump/branch this cycle
redir_jump  in  1  decoder Jump
redir_branch  in  1  decoder Branch
redir_zero  in  1  ALU zero flag
redir_pc_plus4  in  ADDR_W  pc_plus4 of the resolving instruction
redir_imm  in  16  branch offset (instr[15:0])
redir_jidx  in  26  jump index (instr[25:0])

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_plus4_out=0, kill=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: goes to REQ one cycle after reset release.
- REQ: imem_req=1, imem_addr=pc. Memory samples the address only on a req&&gnt cycle, so the address may change while gnt is low. On gnt -> WAIT.
- WAIT: imem_req=0. On rvalid:
  - kill=1: discard the word, clear kill, go to REQ.
  - otherwise: instr_out<=rdata, pc_plus4_out<=pc+4, pc<=pc+4, instr_valid<=1, go to HOLD.
- HOLD: outputs stable while instr_valid && !instr_ready. On handshake: instr_valid<=0, go to REQ next cycle.
- Throughput: at most one instruction per 3 cycles (1-cycle memory latency).
- Taken redirect = redir_valid && (redir_jump || (redir_branch && redir_zero)). Jump has priority over branch.
  - Jump target: {redir_pc_plus4[ADDR_W-1:28], redir_jidx, 2'b00}.
  - Branch target: redir_pc_plus4 + (sext(redir_imm) << 2), modulo 2^ADDR_W.
- On a taken redirect: pc<=target and instr_valid<=0. A handshake in the same cycle is void.
  - In WAIT: kill<=1, stay in WAIT.
  - In REQ with gnt the same cycle: kill<=1, go to WAIT.
  - In REQ without gnt, or in HOLD/IDLE: go to (or stay in) REQ with the new address.
- Redirect and rvalid in the same cycle: the response is discarded, kill is cleared, go to REQ with target.
- Not-taken branch, or redir_valid with neither jump nor branch: no effect.
- PC wraps modulo 2^ADDR_W. Low two PC bits are always 0; target low bits are forced to 0.
- Reset mid-transaction: all state is cleared. A late rvalid arriving in IDLE/REQ is ignored.

Optional Feature:
FETCH_STATS_EN
- Defined: adds outputs stat_fetched[31:0] (incremented per instruction handshake) and stat_killed[31:0] (incremented per discarded response or flushed valid buffer). Both reset to 0 and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_LW=6'h23, OP_SW=6'h2B;
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD};
  - default RESET_PC.
- One combinational sub-module, mips_next_pc: computes jump/branch target and the taken flag from the redir_* inputs.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, ready=1 -> first imem_addr=0x00000000; then 0x4, 0x8. pc_plus4_out=0x4, 0x8, 0xC.
- instr_ready=0 for 5 cycles with instr_valid=1, rdata=0x8C220004 -> instr_out and opcode_out=6'h23 held stable, no new imem_req.
- Jump redir_pc_plus4=0x0000000C, jidx=26'h40 -> next granted address 0x00000100; buffered instruction dropped.
- Branch branch=1, zero=1, pc_plus4=0x10, imm=16'hFFFE -> next address 0x00000008. Same with zero=0 -> sequential fetch continues.
- Redirect during WAIT to 0x200 -> following rvalid discarded (instr_valid stays 0), next request 0x200.
- rst_n low during WAIT, then release -> outputs at reset values; stale rvalid ignored; first request to RESET_PC.
